eth_rx_mac_filter: RTL and testbench

ETH_RX_MAC_FILTER -- requirements
Module: eth_rx_mac_filter

---
 rtl/eth_rx_mac_filter.sv | 141 ++++++++++++++
 tb/tb_eth_rx_mac_filter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_mac_filter.sv
// Serial-to-byte receiver for an Ethernet frame sink with destination-address filtering.
// Assembles LSB-first bytes from an asynchronous sck/mosi/ss link and flags frames not addressed to this station.
module eth_rx_mac_filter #(
  parameter logic [47:0] MAC_ADDR = 48'hFEFAF6F2EEEA,
  parameter int          ADDR_W   = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sck,
  input  logic              mosi,
  input  logic              ss,
  input  logic              ena,
  output logic [7:0]        recv_d,
  output logic [ADDR_W-1:0] recv_byte_cnt,
  output logic              n_recv_buf_we,
  output logic              n_inhibit
);

  localparam logic [ADDR_W-1:0] IDX_MAX = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] DEST_LEN = ADDR_W'(6);

  logic              sck_meta_q, sck_sync_q, sck_prev_q;
  logic              mosi_meta_q, mosi_sync_q;
  logic              ss_meta_q, ss_sync_q;
  logic [7:0]        shift_q, shift_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [ADDR_W-1:0] byte_idx_q, byte_idx_d;
  logic              idx_done_q, idx_done_d;
  logic [7:0]        recv_d_q, recv_d_d;
  logic [ADDR_W-1:0] recv_cnt_q, recv_cnt_d;
  logic              we_n_q, we_n_d;
  logic              ucast_ok_q, ucast_ok_d;
  logic              bcast_ok_q, bcast_ok_d;
  logic              inhibit_n_q, inhibit_n_d;
  logic              sck_rise, bit_take;
  logic [7:0]        mac_byte;

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_meta_q  <= 1'b0;
      sck_sync_q  <= 1'b0;
      sck_prev_q  <= 1'b0;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
      ss_meta_q   <= 1'b0;
      ss_sync_q   <= 1'b0;
      shift_q     <= 8'h00;
      bit_cnt_q   <= 3'd0;
      byte_idx_q  <= '0;
      idx_done_q  <= 1'b0;
      recv_d_q    <= 8'h00;
      recv_cnt_q  <= '0;
      we_n_q      <= 1'b1;
      ucast_ok_q  <= 1'b1;
      bcast_ok_q  <= 1'b1;
      inhibit_n_q <= 1'b1;
    end else begin
      sck_meta_q  <= sck;
      sck_sync_q  <= sck_meta_q;
      sck_prev_q  <= sck_sync_q;
      mosi_meta_q <= mosi;
      mosi_sync_q <= mosi_meta_q;
      ss_meta_q   <= ss;
      ss_sync_q   <= ss_meta_q;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_idx_q  <= byte_idx_d;
      idx_done_q  <= idx_done_d;
      recv_d_q    <= recv_d_d;
      recv_cnt_q  <= recv_cnt_d;
      we_n_q      <= we_n_d;
      ucast_ok_q  <= ucast_ok_d;
      bcast_ok_q  <= bcast_ok_d;
      inhibit_n_q <= inhibit_n_d;
    end
  end

  // Write strobe: n_recv_buf_we is low for exactly one clk cycle per completed byte;
  // recv_d/recv_byte_cnt are valid during that cycle and hold until the next byte.
  always_comb begin
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    byte_idx_d = byte_idx_q;
    idx_done_d = idx_done_q;
    recv_d_d   = recv_d_q;
    recv_cnt_d = recv_cnt_q;
    we_n_d     = 1'b1;
    sck_rise   = sck_sync_q & ~sck_prev_q;
    bit_take   = sck_rise & ss_sync_q & ena;
    if (!ss_sync_q) begin
      shift_d    = 8'h00;
      bit_cnt_d  = 3'd0;
      byte_idx_d = '0;
      idx_done_d = 1'b0;
    end else if (bit_take) begin
      shift_d   = {mosi_sync_q, shift_q[7:1]};
      bit_cnt_d = bit_cnt_q + 3'd1;
      // Once the index has saturated and its byte was written, later bytes are dropped.
      if (bit_cnt_q == 3'd7 && !idx_done_q) begin
        recv_d_d   = shift_d;
        recv_cnt_d = byte_idx_q;
        we_n_d     = 1'b0;
        if (byte_idx_q == IDX_MAX) idx_done_d = 1'b1;
        else                       byte_idx_d = byte_idx_q + ADDR_W'(1);
      end
    end
  end

  always_comb begin
    case (recv_cnt_q[2:0])
      3'd0:    mac_byte = MAC_ADDR[47:40];
      3'd1:    mac_byte = MAC_ADDR[39:32];
      3'd2:    mac_byte = MAC_ADDR[31:24];
      3'd3:    mac_byte = MAC_ADDR[23:16];
      3'd4:    mac_byte = MAC_ADDR[15:8];
      default: mac_byte = MAC_ADDR[7:0];
    endcase
  end

  // The filter judges the byte during its strobe cycle, so rejection lands one edge later.
  always_comb begin
    ucast_ok_d  = ucast_ok_q;
    bcast_ok_d  = bcast_ok_q;
    inhibit_n_d = inhibit_n_q;
    if (!ss_sync_q) begin
      ucast_ok_d  = 1'b1;
      bcast_ok_d  = 1'b1;
      inhibit_n_d = 1'b1;
    end else if (!we_n_q && recv_cnt_q < DEST_LEN) begin
      if (recv_d_q != mac_byte) ucast_ok_d = 1'b0;
      if (recv_d_q != 8'hFF)    bcast_ok_d = 1'b0;
      if (!ucast_ok_d && !bcast_ok_d) inhibit_n_d = 1'b0;
    end
  end

  assign recv_d        = recv_d_q;
  assign recv_byte_cnt = recv_cnt_q;
  assign n_recv_buf_we = we_n_q;
  assign n_inhibit     = inhibit_n_q;

endmodule

// File: tb/tb_eth_rx_mac_filter.sv
// Self-checking bench for eth_rx_mac_filter: table frames, hand-written corner sequences and
// randomized frames scored against a frame-level model of the address filter.
module tb_eth_rx_mac_filter;

  localparam int          ADDR_W  = 5;
  localparam int          IDX_MAX = (1 << ADDR_W) - 1;
  localparam logic [47:0] MAC     = 48'hFEFAF6F2EEEA;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              sck = 1'b0;
  logic              mosi = 1'b0;
  logic              ss = 1'b0;
  logic              ena = 1'b1;
  logic [7:0]        recv_d;
  logic [ADDR_W-1:0] recv_byte_cnt;
  logic              n_recv_buf_we;
  logic              n_inhibit;

  eth_rx_mac_filter #(.MAC_ADDR(MAC), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .sck(sck), .mosi(mosi), .ss(ss), .ena(ena),
    .recv_d(recv_d), .recv_byte_cnt(recv_byte_cnt),
    .n_recv_buf_we(n_recv_buf_we), .n_inhibit(n_inhibit)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish within 60000 cycles");
    $fatal(1);
  end

  // Scoreboard state
  int                n_checks = 0;
  int                n_pass = 0;
  int                strobe_cnt = 0;
  logic [7:0]        exp_q[$];
  logic [ADDR_W-1:0] exp_idx_q[$];
  logic [7:0]        frame_q[$];
  logic [7:0]        last_byte = 8'h00;
  logic              prev_low = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [7:0] mac_byte(input int k);
    return 8'((MAC >> (8 * (5 - k))) & 48'hFF);
  endfunction

  // Strobe monitor: every low n_recv_buf_we cycle must match the next expected byte.
  always @(negedge clk) begin
    if (rst) begin
      prev_low = 1'b0;
    end else begin
      if (n_recv_buf_we === 1'b0) begin
        strobe_cnt++;
        check("strobe_width", {31'd0, prev_low}, 32'd0);
        check("strobe_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          check("strobe_data", {24'd0, recv_d}, {24'd0, exp_q.pop_front()});
          check("strobe_index", 32'(recv_byte_cnt), 32'(exp_idx_q.pop_front()));
        end
      end
      prev_low = (n_recv_buf_we === 1'b0);
    end
  end

  // Driver tasks
  task automatic ghost_pulse();
    @(negedge clk) ena = 1'b0; sck = 1'b0; mosi = 1'($urandom_range(0, 1));
    repeat (4) @(negedge clk);
    sck = 1'b1;
    repeat (4) @(negedge clk);
    sck = 1'b0;
    repeat (4) @(negedge clk);
    ena = 1'b1;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n, input int ghost_at);
    for (int i = 0; i < n; i++) begin
      if (i == ghost_at) ghost_pulse();
      @(negedge clk) mosi = b[i]; sck = 1'b0;
      repeat (4) @(negedge clk);
      sck = 1'b1;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic build_frame(input logic [47:0] dest, input int n);
    frame_q.delete();
    for (int j = 0; j < n; j++) begin
      if (j < 6) frame_q.push_back(8'((dest >> (8 * (5 - j))) & 48'hFF));
      else       frame_q.push_back((j % 2 == 0) ? 8'h77 : 8'h88);
    end
  endtask

  task automatic run_frame(input int ghost_byte, output logic inh_end);
    logic uc_bad, bc_bad;
    logic [7:0] b;
    uc_bad = 1'b0;
    bc_bad = 1'b0;
    @(negedge clk) ss = 1'b1; sck = 1'b0;
    repeat (4) @(negedge clk);
    for (int k = 0; k < frame_q.size(); k++) begin
      b = frame_q[k];
      if (k < 6) begin
        if (b != mac_byte(k)) uc_bad = 1'b1;
        if (b != 8'hFF)       bc_bad = 1'b1;
      end
      if (k <= IDX_MAX) begin
        exp_q.push_back(b);
        exp_idx_q.push_back(ADDR_W'(k));
        last_byte = b;
      end
      send_bits(b, 8, (k == ghost_byte) ? int'($urandom_range(0, 7)) : -1);
      repeat (2) @(negedge clk);
      check("inhibit_mid", {31'd0, n_inhibit}, {31'd0, !(uc_bad && bc_bad)});
    end
    inh_end = n_inhibit;
    @(negedge clk) sck = 1'b0;
    repeat (4) @(negedge clk);
    ss = 1'b0;
    repeat (3) @(negedge clk);
    check("inhibit_recover", {31'd0, n_inhibit}, 32'd1);
    check("strobes_drained", 32'(exp_q.size()), 32'd0);
    check("recv_d_hold", {24'd0, recv_d}, {24'd0, last_byte});
    repeat (4) @(negedge clk);
  endtask

  typedef struct {
    logic [47:0] dest;
    int          n_bytes;
    logic        exp_inh;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic inh;
    logic [47:0] dest;
    int cnt0, kind, n;

    vecs[0] = '{48'hFEFAF6F2EEEA, 20, 1'b1};
    vecs[1] = '{48'hFEDAF6F2EEEA,  8, 1'b0};
    vecs[2] = '{48'hFFFFFFFFFFFF,  8, 1'b1};
    vecs[3] = '{48'hFEFAF7F2EEEA,  8, 1'b0};
    vecs[4] = '{48'hFFFAF6F2EEEA,  7, 1'b0};
    vecs[5] = '{48'hFEFAF6000000,  3, 1'b1};
    vecs[6] = '{48'h000000000000,  1, 1'b0};
    vecs[7] = '{48'hFEFAF6F2EEEB,  6, 1'b0};

    repeat (5) @(negedge clk);
    check("rst_recv_d", {24'd0, recv_d}, 32'd0);
    check("rst_byte_cnt", 32'(recv_byte_cnt), 32'd0);
    check("rst_we_n", {31'd0, n_recv_buf_we}, 32'd1);
    check("rst_inhibit_n", {31'd0, n_inhibit}, 32'd1);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    foreach (vecs[v]) begin
      build_frame(vecs[v].dest, vecs[v].n_bytes);
      run_frame(-1, inh);
      check("table_inhibit_end", {31'd0, inh}, {31'd0, vecs[v].exp_inh});
    end

    // Partial byte then a fresh frame
    cnt0 = strobe_cnt;
    @(negedge clk) ss = 1'b1;
    repeat (4) @(negedge clk);
    send_bits(8'hA5, 4, -1);
    @(negedge clk) sck = 1'b0;
    repeat (4) @(negedge clk);
    ss = 1'b0;
    repeat (6) @(negedge clk);
    check("partial_no_strobe", 32'(strobe_cnt), 32'(cnt0));
    build_frame(48'h123456789ABC, 3);
    run_frame(-1, inh);

    // Reset mid-frame after a rejection
    @(negedge clk) ss = 1'b1;
    repeat (4) @(negedge clk);
    exp_q.push_back(8'h00);
    exp_idx_q.push_back('0);
    send_bits(8'h00, 8, -1);
    repeat (2) @(negedge clk);
    check("inhibit_pre_rst", {31'd0, n_inhibit}, 32'd0);
    send_bits(8'h3C, 3, -1);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    check("midrst_recv_d", {24'd0, recv_d}, 32'd0);
    check("midrst_byte_cnt", 32'(recv_byte_cnt), 32'd0);
    check("midrst_we_n", {31'd0, n_recv_buf_we}, 32'd1);
    check("midrst_inhibit_n", {31'd0, n_inhibit}, 32'd1);
    check("midrst_queue", 32'(exp_q.size()), 32'd0);
    sck = 1'b0;
    ss = 1'b0;
    last_byte = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    build_frame(vecs[0].dest, 8);
    run_frame(-1, inh);
    check("post_rst_inhibit_end", {31'd0, inh}, 32'd1);

    // Randomized frames, some with ignored sck pulses while ena is low
    for (int r = 0; r < 12; r++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: dest = MAC;
        1: dest = 48'hFFFFFFFFFFFF;
        2: dest = MAC ^ (48'd1 << (8 * $urandom_range(0, 5) + $urandom_range(0, 7)));
        default: dest = {$urandom, 16'($urandom)};
      endcase
      n = $urandom_range(1, 10);
      build_frame(dest, n);
      run_frame(($urandom_range(0, 1) == 1) ? int'($urandom_range(0, n - 1)) : -1, inh);
    end

    // Byte index saturation: bytes past the last index produce no strobe
    frame_q.delete();
    for (int j = 0; j < IDX_MAX + 3; j++)
      frame_q.push_back((j < 6) ? mac_byte(j) : 8'($urandom_range(0, 255)));
    run_frame(-1, inh);
    check("sat_inhibit_end", {31'd0, inh}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
